// File: rtl/dual_issue_scoreboard.sv
// Issue-stage scoreboard for a dual-issue pipeline: tracks pending result latency
// per register and decides each cycle whether the master and slave slots may issue.
module dual_issue_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             a_valid,
  input  logic [4:0]       a_rs,
  input  logic             a_rs_en,
  input  logic [4:0]       a_rt,
  input  logic             a_rt_en,
  input  logic             a_wen,
  input  logic [4:0]       a_rd,
  input  logic [LAT_W-1:0] a_lat,
  input  logic             b_valid,
  input  logic [4:0]       b_rs,
  input  logic             b_rs_en,
  input  logic [4:0]       b_rt,
  input  logic             b_rt_en,
  input  logic             b_wen,
  input  logic [4:0]       b_rd,
  input  logic [LAT_W-1:0] b_lat,
  output logic             issue_a,
  output logic             issue_b,
  output logic [NREG-1:0]  busy_mask,
  output logic [31:0]      stall_cnt
);

  logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [31:0]                stall_cnt_q, stall_cnt_d;

  logic a_ops_ok, b_ops_ok, pair_raw;

  // busy_q mirrors cnt_q != 0, so readiness can be read straight from the mask.
  function automatic logic reg_ready(input logic [4:0] r, input logic [NREG-1:0] busy);
    return (r == 5'd0) || !busy[r];
  endfunction

  // Hazard evaluation and issue decision for both slots.
  always_comb begin
    a_ops_ok = (!a_rs_en || reg_ready(a_rs, busy_q)) &&
               (!a_rt_en || reg_ready(a_rt, busy_q)) &&
               (!a_wen   || reg_ready(a_rd, busy_q));
    b_ops_ok = (!b_rs_en || reg_ready(b_rs, busy_q)) &&
               (!b_rt_en || reg_ready(b_rt, busy_q)) &&
               (!b_wen   || reg_ready(b_rd, busy_q));
    pair_raw = a_wen && (a_rd != 5'd0) &&
               ((b_rs_en && (b_rs == a_rd)) || (b_rt_en && (b_rt == a_rd)));
    issue_a  = rst && a_valid && !stall_i && !flush_i && a_ops_ok;
    issue_b  = issue_a && b_valid && b_ops_ok && !pair_raw;
  end

  // Next-state latency counters; the slave write is checked first so it wins a pair WAW.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (flush_i) begin
        cnt_d[r] = '0;
      end else if (issue_b && b_wen && (b_rd == 5'(r))) begin
        cnt_d[r] = b_lat;
      end else if (issue_a && a_wen && (a_rd == 5'(r))) begin
        cnt_d[r] = a_lat;
      end else if (stall_i) begin
        cnt_d[r] = cnt_q[r];
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Busy mask derived from next-state counters and the blocked-issue counter.
  always_comb begin
    busy_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_d[r] = (cnt_d[r] != '0);
    end
    if (a_valid && !issue_a) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset drops every pending latency immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      busy_q      <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_mask = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule
